// File: rtl/sram_axi_dbridge_if.sv
// Bundle of the core-side SRAM-like data port and the AXI3 master channels of the data bridge.
// 'master' is the bridge view; 'slave' is the view of the core plus AXI fabric around it.
interface sram_axi_dbridge_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ID_W   = 4;

    logic                  data_req;
    logic                  data_wr;
    logic [1:0]            data_size;
    logic [ADDR_W-1:0]     data_addr;
    logic [DATA_W-1:0]     data_wdata;
    logic                  data_addr_ok;
    logic                  data_data_ok;
    logic [DATA_W-1:0]     data_rdata;

    logic [ID_W-1:0]       arid;
    logic [ADDR_W-1:0]     araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic [1:0]            arlock;
    logic [3:0]            arcache;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;

    logic [ID_W-1:0]       rid;
    logic [DATA_W-1:0]     rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    logic [ID_W-1:0]       awid;
    logic [ADDR_W-1:0]     awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic [1:0]            awlock;
    logic [3:0]            awcache;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;

    logic [ID_W-1:0]       wid;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;

    logic [ID_W-1:0]       bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    modport master (
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/sram_axi_dbridge.sv
// Data-side SRAM-like to AXI3 bridge: one outstanding single-beat load or store at a time.
// Request fields are latched on acceptance so AXI payloads stay stable until their handshakes.
module sram_axi_dbridge #(
    parameter int unsigned ID = 1
) (
    input  logic                clk,
    input  logic                reset,
    sram_axi_dbridge_if.master  bus
);
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ID_W   = 4;
    localparam int unsigned STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_A  = 3'd1,
        S_RD_D  = 3'd2,
        S_WR_AW = 3'd3,
        S_WR_B  = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic                r_wr;
    logic [1:0]          r_size;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_aw_done;
    logic                r_w_done;

    logic                w_accept;
    logic                w_ar_hs;
    logic                w_r_hs;
    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_b_hs;
    logic                w_arvalid;
    logic                w_rready;
    logic                w_awvalid;
    logic                w_wvalid;
    logic                w_bready;
    logic                w_data_ok;
    logic [STRB_W-1:0]   w_wstrb;
    logic                w_unused;

    assign w_accept = (r_state == S_IDLE) && bus.data_req;
    assign w_ar_hs  = w_arvalid && bus.arready;
    assign w_r_hs   = w_rready  && bus.rvalid;
    assign w_aw_hs  = w_awvalid && bus.awready;
    assign w_w_hs   = w_wvalid  && bus.wready;
    assign w_b_hs   = w_bready  && bus.bvalid;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a store leaves WR_AW once both AW and W are done, counting this cycle's handshakes
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = bus.data_wr ? S_WR_AW : S_RD_A;
            S_RD_A:  if (w_ar_hs)  w_next = S_RD_D;
            S_RD_D:  if (w_r_hs)   w_next = S_RESP;
            S_WR_AW: if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_next = S_WR_B;
            S_WR_B:  if (w_b_hs)   w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        w_arvalid = 1'b0;
        w_rready  = 1'b0;
        w_awvalid = 1'b0;
        w_wvalid  = 1'b0;
        w_bready  = 1'b0;
        w_data_ok = 1'b0;
        case (r_state)
            S_RD_A:  w_arvalid = 1'b1;
            S_RD_D:  w_rready  = 1'b1;
            S_WR_AW: begin
                w_awvalid = !r_aw_done;
                w_wvalid  = !r_w_done;
            end
            S_WR_B:  w_bready  = 1'b1;
            S_RESP:  w_data_ok = 1'b1;
            default: ;
        endcase
    end

    // Request capture, load data capture and AW/W completion tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr      <= 1'b0;
            r_size    <= 2'd0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wr      <= bus.data_wr;
                r_size    <= bus.data_size;
                r_addr    <= bus.data_addr;
                r_wdata   <= bus.data_wdata;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end else begin
                if (w_aw_hs) r_aw_done <= 1'b1;
                if (w_w_hs)  r_w_done  <= 1'b1;
            end
            if (w_r_hs) r_rdata <= bus.rdata;
        end
    end

    // Byte lanes for the store; size 3 falls through to a full word
    always_comb begin
        w_wstrb = 4'b1111;
        case (r_size)
            2'd0:    w_wstrb = 4'b0001 << r_addr[1:0];
            2'd1:    w_wstrb = r_addr[1] ? 4'b1100 : 4'b0011;
            default: w_wstrb = 4'b1111;
        endcase
    end

    assign bus.data_addr_ok = w_accept;
    assign bus.data_data_ok = w_data_ok;
    assign bus.data_rdata   = r_rdata;

    assign bus.arid    = ID_W'(ID);
    assign bus.araddr  = r_addr;
    assign bus.arlen   = 8'd0;
    assign bus.arsize  = {1'b0, r_size};
    assign bus.arburst = 2'b01;
    assign bus.arlock  = 2'b00;
    assign bus.arcache = 4'd0;
    assign bus.arprot  = 3'd0;
    assign bus.arvalid = w_arvalid;
    assign bus.rready  = w_rready;

    assign bus.awid    = ID_W'(ID);
    assign bus.awaddr  = r_addr;
    assign bus.awlen   = 8'd0;
    assign bus.awsize  = {1'b0, r_size};
    assign bus.awburst = 2'b01;
    assign bus.awlock  = 2'b00;
    assign bus.awcache = 4'd0;
    assign bus.awprot  = 3'd0;
    assign bus.awvalid = w_awvalid;

    assign bus.wid     = ID_W'(ID);
    assign bus.wdata   = r_wdata;
    assign bus.wstrb   = w_wstrb;
    assign bus.wlast   = 1'b1;
    assign bus.wvalid  = w_wvalid;
    assign bus.bready  = w_bready;

    // Response IDs, status and rlast carry no information for a single-beat, error-free bridge
    assign w_unused = ^{bus.rid, bus.rresp, bus.rlast, bus.bid, bus.bresp, r_wr};
endmodule

// File: tb/tb_sram_axi_dbridge.sv
// Directed bench for sram_axi_dbridge: vector table of single transactions plus
// cycle-by-cycle sequences for AW/W skew, held requests with AR stall, and mid-read reset.
module tb_sram_axi_dbridge;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    sram_axi_dbridge_if bus();

    sram_axi_dbridge #(.ID(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata_in;
        logic [2:0]  exp_axsize;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.data_req   = 1'b0;
        bus.data_wr    = 1'b0;
        bus.data_size  = 2'd0;
        bus.data_addr  = 32'd0;
        bus.data_wdata = 32'd0;
        bus.arready    = 1'b0;
        bus.rid        = 4'd0;
        bus.rdata      = 32'd0;
        bus.rresp      = 2'd0;
        bus.rlast      = 1'b1;
        bus.rvalid     = 1'b0;
        bus.awready    = 1'b0;
        bus.wready     = 1'b0;
        bus.bid        = 4'd0;
        bus.bresp      = 2'd0;
        bus.bvalid     = 1'b0;
    endtask

    // One transaction with every AXI response returned immediately: minimum latency path
    task automatic do_txn(input int idx, input vec_t v);
        @(negedge clk);
        bus.data_req   = 1'b1;
        bus.data_wr    = v.wr;
        bus.data_size  = v.size;
        bus.data_addr  = v.addr;
        bus.data_wdata = v.wdata;
        bus.arready    = 1'b1;
        bus.rvalid     = 1'b1;
        bus.rdata      = v.rdata_in;
        bus.awready    = 1'b1;
        bus.wready     = 1'b1;
        bus.bvalid     = 1'b1;
        #1;
        chk($sformatf("v%0d addr_ok c0", idx), 32'(bus.data_addr_ok), 32'd1);
        chk($sformatf("v%0d data_ok c0", idx), 32'(bus.data_data_ok), 32'd0);

        @(negedge clk);
        bus.data_req = 1'b0;
        #1;
        chk($sformatf("v%0d addr_ok c1", idx), 32'(bus.data_addr_ok), 32'd0);
        if (!v.wr) begin
            chk($sformatf("v%0d arvalid", idx), 32'(bus.arvalid), 32'd1);
            chk($sformatf("v%0d awvalid", idx), 32'(bus.awvalid), 32'd0);
            chk($sformatf("v%0d araddr", idx),  bus.araddr, v.addr);
            chk($sformatf("v%0d arsize", idx),  32'(bus.arsize), 32'(v.exp_axsize));
            chk($sformatf("v%0d arlen", idx),   32'(bus.arlen), 32'd0);
            chk($sformatf("v%0d arburst", idx), 32'(bus.arburst), 32'd1);
            chk($sformatf("v%0d arid", idx),    32'(bus.arid), 32'd1);
        end else begin
            chk($sformatf("v%0d awvalid", idx), 32'(bus.awvalid), 32'd1);
            chk($sformatf("v%0d wvalid", idx),  32'(bus.wvalid), 32'd1);
            chk($sformatf("v%0d arvalid", idx), 32'(bus.arvalid), 32'd0);
            chk($sformatf("v%0d awaddr", idx),  bus.awaddr, v.addr);
            chk($sformatf("v%0d awsize", idx),  32'(bus.awsize), 32'(v.exp_axsize));
            chk($sformatf("v%0d wstrb", idx),   32'(bus.wstrb), 32'(v.exp_wstrb));
            chk($sformatf("v%0d wdata", idx),   bus.wdata, v.wdata);
            chk($sformatf("v%0d wlast", idx),   32'(bus.wlast), 32'd1);
            chk($sformatf("v%0d awlen", idx),   32'(bus.awlen), 32'd0);
            chk($sformatf("v%0d awburst", idx), 32'(bus.awburst), 32'd1);
            chk($sformatf("v%0d wid", idx),     32'(bus.wid), 32'd1);
        end

        @(negedge clk);
        #1;
        if (!v.wr) chk($sformatf("v%0d rready", idx), 32'(bus.rready), 32'd1);
        else       chk($sformatf("v%0d bready", idx), 32'(bus.bready), 32'd1);
        chk($sformatf("v%0d data_ok c2", idx), 32'(bus.data_data_ok), 32'd0);

        @(negedge clk);
        #1;
        chk($sformatf("v%0d data_ok c3", idx), 32'(bus.data_data_ok), 32'd1);
        if (!v.wr) chk($sformatf("v%0d rdata", idx), bus.data_rdata, v.exp_rdata);

        @(negedge clk);
        idle_inputs();
        #1;
        chk($sformatf("v%0d data_ok c4", idx), 32'(bus.data_data_ok), 32'd0);
    endtask

    initial begin
        logic [7:0]  e_aw, e_w, e_b, e_ok;
        logic [15:0] p_aok, p_dok, p_ar, p_r;
        int          n_aok, n_dok;

        total = 0;
        bad   = 0;
        idle_inputs();
        reset = 1'b1;

        vecs[0] = '{1'b0, 2'd2, 32'h1FC0_0010, 32'h0,          32'hDEAD_BEEF, 3'd2, 4'b1111, 32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 2'd1, 32'h8000_1000, 32'h0000_1234, 32'h0,          3'd1, 4'b0011, 32'h0};
        vecs[2] = '{1'b1, 2'd1, 32'h8000_1002, 32'h5678_0000, 32'h0,          3'd1, 4'b1100, 32'h0};
        vecs[3] = '{1'b1, 2'd2, 32'h8000_1004, 32'hCAFE_F00D, 32'h0,          3'd2, 4'b1111, 32'h0};
        vecs[4] = '{1'b1, 2'd0, 32'h8000_1001, 32'h0000_BB00, 32'h0,          3'd0, 4'b0010, 32'h0};
        vecs[5] = '{1'b1, 2'd3, 32'h8000_1008, 32'h0102_0304, 32'h0,          3'd3, 4'b1111, 32'h0};
        vecs[6] = '{1'b0, 2'd0, 32'h8000_2005, 32'h0,          32'h1234_5678, 3'd0, 4'b1111, 32'h1234_5678};
        vecs[7] = '{1'b0, 2'd1, 32'h8000_2002, 32'h0,          32'hA5A5_5A5A, 3'd1, 4'b1111, 32'hA5A5_5A5A};

        repeat (3) @(negedge clk);
        #1;
        chk("rst arvalid", 32'(bus.arvalid), 32'd0);
        chk("rst rready",  32'(bus.rready),  32'd0);
        chk("rst awvalid", 32'(bus.awvalid), 32'd0);
        chk("rst wvalid",  32'(bus.wvalid),  32'd0);
        chk("rst bready",  32'(bus.bready),  32'd0);
        chk("rst data_ok", 32'(bus.data_data_ok), 32'd0);
        chk("rst rdata",   bus.data_rdata, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) do_txn(i, vecs[i]);

        // Byte store, W accepted at once, AW accepted three cycles late
        e_aw = 8'b0001_1110;
        e_w  = 8'b0000_0010;
        e_b  = 8'b0010_0000;
        e_ok = 8'b0100_0000;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            bus.data_req = (c == 0);
            if (c == 0) begin
                bus.data_wr    = 1'b1;
                bus.data_size  = 2'd0;
                bus.data_addr  = 32'h8000_0003;
                bus.data_wdata = 32'hAA00_0000;
            end
            bus.awready = (c == 4);
            bus.wready  = 1'b1;
            bus.bvalid  = (c == 5);
            #1;
            chk($sformatf("skew awvalid c%0d", c), 32'(bus.awvalid), 32'(e_aw[c]));
            chk($sformatf("skew wvalid c%0d", c),  32'(bus.wvalid),  32'(e_w[c]));
            chk($sformatf("skew bready c%0d", c),  32'(bus.bready),  32'(e_b[c]));
            chk($sformatf("skew data_ok c%0d", c), 32'(bus.data_data_ok), 32'(e_ok[c]));
            if (c == 1) begin
                chk("skew wstrb",  32'(bus.wstrb), 32'b1000);
                chk("skew awsize", 32'(bus.awsize), 32'd0);
                chk("skew wdata",  bus.wdata, 32'hAA00_0000);
            end
            if (c >= 1 && c <= 4) chk($sformatf("skew awaddr c%0d", c), bus.awaddr, 32'h8000_0003);
        end
        idle_inputs();

        // Two loads with data_req held high; first AR stalled five cycles
        p_aok = 16'h0201;
        p_dok = 16'h1100;
        p_ar  = 16'h047E;
        p_r   = 16'h0880;
        n_aok = 0;
        n_dok = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            bus.data_req   = (c <= 9);
            bus.data_wr    = 1'b0;
            bus.data_size  = 2'd2;
            bus.data_addr  = (c == 0) ? 32'h0000_0100 : 32'h0000_0200;
            bus.arready    = (c >= 6);
            bus.rvalid     = 1'b1;
            bus.rdata      = (c < 9) ? 32'h1111_1111 : 32'h2222_2222;
            #1;
            if (bus.data_addr_ok === 1'b1) n_aok++;
            if (bus.data_data_ok === 1'b1) n_dok++;
            chk($sformatf("held addr_ok c%0d", c), 32'(bus.data_addr_ok), 32'(p_aok[c]));
            chk($sformatf("held data_ok c%0d", c), 32'(bus.data_data_ok), 32'(p_dok[c]));
            chk($sformatf("held arvalid c%0d", c), 32'(bus.arvalid), 32'(p_ar[c]));
            chk($sformatf("held rready c%0d", c),  32'(bus.rready),  32'(p_r[c]));
            if (p_ar[c]) begin
                chk($sformatf("held araddr c%0d", c), bus.araddr, (c < 9) ? 32'h0000_0100 : 32'h0000_0200);
                chk($sformatf("held arsize c%0d", c), 32'(bus.arsize), 32'd2);
            end
            if (c == 8)  chk("held rdata 1", bus.data_rdata, 32'h1111_1111);
            if (c == 12) chk("held rdata 2", bus.data_rdata, 32'h2222_2222);
        end
        chk("held addr_ok count", 32'(n_aok), 32'd2);
        chk("held data_ok count", 32'(n_dok), 32'd2);
        idle_inputs();

        // Reset while waiting in RD_D, then a normal load
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus.data_req  = (c == 0);
            bus.data_wr   = 1'b0;
            bus.data_size = 2'd2;
            bus.data_addr = 32'h0000_0300;
            bus.arready   = 1'b1;
            bus.rvalid    = 1'b0;
            #1;
            if (c == 1) chk("rrst arvalid c1", 32'(bus.arvalid), 32'd1);
            if (c == 2) begin
                chk("rrst rready c2", 32'(bus.rready), 32'd1);
                reset = 1'b1;
            end
        end
        @(negedge clk);
        bus.rvalid = 1'b1;
        bus.rdata  = 32'h5555_AAAA;
        #1;
        chk("rrst arvalid", 32'(bus.arvalid), 32'd0);
        chk("rrst rready",  32'(bus.rready),  32'd0);
        chk("rrst awvalid", 32'(bus.awvalid), 32'd0);
        chk("rrst wvalid",  32'(bus.wvalid),  32'd0);
        chk("rrst bready",  32'(bus.bready),  32'd0);
        chk("rrst data_ok", 32'(bus.data_data_ok), 32'd0);
        chk("rrst rdata",   bus.data_rdata, 32'd0);
        reset = 1'b0;
        idle_inputs();
        @(negedge clk);
        #1;
        chk("rrst idle data_ok", 32'(bus.data_data_ok), 32'd0);
        chk("rrst idle rdata",   bus.data_rdata, 32'd0);
        do_txn(100, vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Backstop so a wedged run still terminates with a report
    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/sram_axi_dbridge.md
# sram_axi_dbridge

Data-side responder for the core's SRAM-like memory interface. It accepts `data_req` transactions from the EX stage, answers with `data_addr_ok` and `data_data_ok`, and turns each one into a single-beat AXI3 read or write. It sits between the core's data port and the AXI crossbar. It is the block that produces the handshakes the pipeline control unit stalls on. One transaction is outstanding at a time.

## Interface
- `ID`, default 1, AXI ID driven on `arid`/`awid`/`wid`.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `data_req` in 1: request valid.
- `data_wr` in 1: 1 = store, 0 = load.
- `data_size` in 2: 0 = byte, 1 = half, 2 = word.
- `data_addr` in 32: byte address.
- `data_wdata` in 32: store data, already lane-aligned by the core.
- `data_addr_ok` out 1: request accepted this cycle.
- `data_data_ok` out 1: load data valid, or store complete; one-cycle pulse.
- `data_rdata` out 32: load data, valid while `data_data_ok` is high.
- AR channel:
  - `arid` out 4, `araddr` out 32, `arlen` out 8, `arsize` out 3, `arburst` out 2, `arlock` out 2, `arcache` out 4, `arprot` out 3.
  - `arvalid` out 1, `arready` in 1.
- R channel: `rid` in 4, `rdata` in 32, `rresp` in 2, `rlast` in 1, `rvalid` in 1, `rready` out 1.
- AW channel: `awid`, `awaddr`, `awlen`, `awsize`, `awburst`, `awlock`, `awcache`, `awprot` (same widths as AR), `awvalid` out 1, `awready` in 1.
- W channel: `wid` out 4, `wdata` out 32, `wstrb` out 4, `wlast` out 1, `wvalid` out 1, `wready` in 1.
- B channel: `bid` in 4, `bresp` in 2, `bvalid` in 1, `bready` out 1.

## Operation
- States: IDLE, RD_A, RD_D, WR_AW, WR_B, RESP.
- `data_addr_ok = (state==IDLE) && data_req`, combinational.
  - On acceptance, latch wr, size, addr and wdata.
  - Go to RD_A if the request is a load, WR_AW if it is a store.
- RD_A: `arvalid=1`. When `arready` is seen, go to RD_D.
- RD_D: `rready=1`. On `rvalid`, latch `rdata` into `data_rdata` and go to RESP.
- WR_AW: `awvalid` and `wvalid` are raised together on entry.
  - Each one drops independently after its own handshake; the two may complete in either order or in the same cycle.
  - Two done-flags track completion. When both are set, go to WR_B.
- WR_B: `bready=1`. On `bvalid`, go to RESP.
- RESP: `data_data_ok=1` for exactly one cycle, then IDLE. `data_addr_ok` is 0 in RESP.
- Constant AXI fields:
  - `arlen`/`awlen` = 0, `arburst`/`awburst` = 2'b01, `*lock`/`*cache`/`*prot` = 0, `wlast` = 1.
  - `arsize`/`awsize` = {1'b0, size}. Address is passed through unmodified.
- `wstrb` from the latched size and addr[1:0]:
  - size 0: 4'b0001 << addr[1:0].
  - size 1: addr[1] ? 4'b1100 : 4'b0011.
  - size 2: 4'b1111.
  - size 3: treated as word.
- `rresp`, `bresp`, `rid`, `bid` and `rlast` are ignored. No error reporting.
- AXI outputs are stable while their valid is high and the handshake is pending. This follows from latched request registers that only change in IDLE.

## Timing
- Reset values: state IDLE, all valid/ready outputs 0, `data_data_ok` 0, `data_rdata` 0, done-flags 0.
- Reset at any point returns to IDLE at the next edge. An abandoned AXI transaction is legal only under global reset.
- Minimum load latency, with `arready` and `rvalid` returned immediately:
  - addr_ok in cycle 0, arvalid/arready in cycle 1, rvalid in cycle 2, data_ok in cycle 3.
- Minimum store latency:
  - addr_ok in cycle 0, aw/w handshakes in cycle 1, bvalid in cycle 2, data_ok in cycle 3.
- Back-to-back requests: the next `data_addr_ok` comes no earlier than the cycle after the RESP cycle.
- `data_req` held in any non-IDLE state is not accepted; `data_addr_ok` stays 0.

## Test plan
- Word load at 0x1FC0_0010, `arready` and `rvalid` tied to 1, `rdata=0xDEADBEEF`:
  - addr_ok in cycle 0, arvalid in cycle 1 with araddr 0x1FC0_0010 and arsize 2, data_ok in cycle 3 with rdata 0xDEADBEEF, no extra pulses.
- Byte store at addr 0x...03, wdata 0xAA000000:
  - wstrb 4'b1000, awsize 0.
  - `awready` delayed 3 cycles, `wready` immediate: wvalid drops after 1 cycle, awvalid holds until cycle 4, bready only after both complete, data_ok the cycle after bvalid.
- Halfword stores at addr[1]=0 and addr[1]=1:
  - wstrb 4'b0011 and 4'b1100 respectively.
- `data_req` held high continuously over two loads, `arready` stalled 5 cycles:
  - exactly two addr_ok pulses and two data_ok pulses.
  - AR outputs stable during the stall.
  - Second addr_ok no earlier than the cycle after the first data_ok.
- `reset` asserted while in RD_D:
  - next cycle all valids, `rready` and `data_data_ok` are 0 and the state is IDLE.
  - A new load then completes normally.
